// File: rtl/spi_regs_pkg.sv
// Shared definitions for the SPI register-access path: decoder state encoding,
// command byte field positions and the default device ID.
package spi_regs_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StCmd,
      StRdCap,
      StData
   } state_e;

   localparam int unsigned CMD_RW_BIT = 7;
   localparam int unsigned CMD_AI_BIT = 6;

   localparam logic [7:0] DEV_ID_DEFAULT = 8'hA5;

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Byte-level link from spi_bridge plus the peripheral register bus, as seen by
// the command decoder (master) and by its environment (slave).
interface spi_cmd_decoder_if #(
   parameter int unsigned ADDR_W = 6
) ();

   logic              cs_n;
   logic              byte_sync;
   logic [7:0]        data_in;
   logic [7:0]        data_out;
   logic [ADDR_W-1:0] reg_addr;
   logic [7:0]        reg_wdata;
   logic              reg_we;
   logic              reg_re;
   logic [7:0]        reg_rdata;
   logic              err_flag;
   logic              err_clr;

   modport master (
      input  cs_n, byte_sync, data_in, reg_rdata, err_clr,
      output data_out, reg_addr, reg_wdata, reg_we, reg_re, err_flag
   );

   modport slave (
      output cs_n, byte_sync, data_in, reg_rdata, err_clr,
      input  data_out, reg_addr, reg_wdata, reg_we, reg_re, err_flag
   );

endinterface

// File: rtl/spi_sync2.sv
// Two-flop synchronizer for a single asynchronous pad input.
module spi_sync2 #(
   parameter logic ResetVal = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= ResetVal;
         sync_q <= ResetVal;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Turns SPI frames (command byte + data bytes) into register-bus read/write strobes
// and supplies the next MISO byte to spi_bridge.
module spi_cmd_decoder
   import spi_regs_pkg::*;
#(
   parameter int unsigned ADDR_W   = 6,
   parameter int unsigned NUM_REGS = 64,
   parameter logic [7:0]  DEV_ID   = DEV_ID_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   spi_cmd_decoder_if.master bus_io
);

   logic cs_s;

   // Resets to "selected" so a frame already in progress at reset release is not armed.
   spi_sync2 #(
      .ResetVal(1'b0)
   ) u_cs_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d_i  (bus_io.cs_n),
      .q_o  (cs_s)
   );

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return 32'(a) < NUM_REGS;
   endfunction

   state_e            state_q, state_d;
   logic              rw_q, rw_d;
   logic              ai_q, ai_d;
   logic              armed_q, armed_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
   logic [7:0]        reg_wdata_q, reg_wdata_d;
   logic              reg_we_q, reg_we_d;
   logic              reg_re_q, reg_re_d;
   logic [7:0]        data_out_q, data_out_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] cmd_addr;
   logic [ADDR_W-1:0] addr_nxt;

   assign cmd_addr = bus_io.data_in[ADDR_W-1:0];
   assign addr_nxt = ai_q ? addr_q + 1'b1 : addr_q;

   always_comb begin
      state_d     = state_q;
      rw_d        = rw_q;
      ai_d        = ai_q;
      armed_d     = armed_q | cs_s;
      addr_d      = addr_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_we_d    = 1'b0;
      reg_re_d    = 1'b0;
      data_out_d  = data_out_q;
      err_d       = err_q & ~bus_io.err_clr;

      case (state_q)
         StIdle: begin
            if (armed_q && !cs_s && bus_io.byte_sync) begin
               rw_d    = bus_io.data_in[CMD_RW_BIT];
               ai_d    = bus_io.data_in[CMD_AI_BIT];
               addr_d  = cmd_addr;
               state_d = StCmd;
               // Read strobe is registered so it is high for exactly the CMD cycle.
               if (!bus_io.data_in[CMD_RW_BIT]) begin
                  reg_re_d   = 1'b1;
                  reg_addr_d = cmd_addr;
                  if (!in_range(cmd_addr)) err_d = 1'b1;
               end
            end
         end

         StCmd: begin
            if (cs_s)      state_d = StIdle;
            else if (rw_q) state_d = StData;
            else           state_d = StRdCap;
         end

         StRdCap: begin
            if (cs_s) begin
               state_d = StIdle;
            end else begin
               data_out_d = in_range(addr_q) ? bus_io.reg_rdata : 8'h00;
               state_d    = StData;
            end
         end

         StData: begin
            if (bus_io.byte_sync) begin
               if (rw_q) begin
                  if (in_range(addr_q)) begin
                     reg_we_d    = 1'b1;
                     reg_wdata_d = bus_io.data_in;
                     reg_addr_d  = addr_q;
                  end else begin
                     err_d = 1'b1;
                  end
               end
               addr_d = addr_nxt;
               // A byte completing as chip select rises still commits, but starts no prefetch.
               if (cs_s) begin
                  state_d = StIdle;
               end else if (!rw_q) begin
                  state_d    = StCmd;
                  reg_re_d   = 1'b1;
                  reg_addr_d = addr_nxt;
                  if (!in_range(addr_nxt)) err_d = 1'b1;
               end
            end else if (cs_s) begin
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase

      if (cs_s) data_out_d = DEV_ID;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         rw_q        <= 1'b0;
         ai_q        <= 1'b0;
         armed_q     <= 1'b0;
         addr_q      <= '0;
         reg_addr_q  <= '0;
         reg_wdata_q <= 8'h00;
         reg_we_q    <= 1'b0;
         reg_re_q    <= 1'b0;
         data_out_q  <= DEV_ID;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rw_q        <= rw_d;
         ai_q        <= ai_d;
         armed_q     <= armed_d;
         addr_q      <= addr_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_we_q    <= reg_we_d;
         reg_re_q    <= reg_re_d;
         data_out_q  <= data_out_d;
         err_q       <= err_d;
      end
   end

   assign bus_io.data_out  = data_out_q;
   assign bus_io.reg_addr  = reg_addr_q;
   assign bus_io.reg_wdata = reg_wdata_q;
   assign bus_io.reg_we    = reg_we_q;
   assign bus_io.reg_re    = reg_re_q;
   assign bus_io.err_flag  = err_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench: dut_a uses the full 64-register map, dut_b has NUM_REGS=32 for
// out-of-range accesses; both see identical stimulus.
module tb_spi_cmd_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cs_n = 1'b1;
   logic       byte_sync = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] reg_rdata = 8'h00;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_cmd_decoder_if #(.ADDR_W(6)) if_a ();
   spi_cmd_decoder_if #(.ADDR_W(6)) if_b ();

   assign if_a.cs_n      = cs_n;
   assign if_a.byte_sync = byte_sync;
   assign if_a.data_in   = data_in;
   assign if_a.reg_rdata = reg_rdata;
   assign if_a.err_clr   = err_clr;
   assign if_b.cs_n      = cs_n;
   assign if_b.byte_sync = byte_sync;
   assign if_b.data_in   = data_in;
   assign if_b.reg_rdata = reg_rdata;
   assign if_b.err_clr   = err_clr;

   spi_cmd_decoder #(.ADDR_W(6), .NUM_REGS(64), .DEV_ID(8'hA5)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus_io(if_a)
   );

   spi_cmd_decoder #(.ADDR_W(6), .NUM_REGS(32), .DEV_ID(8'hA5)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus_io(if_b)
   );

   // Write log entries are {2'b00, addr, data}.
   logic [15:0] we_log_a[$];
   logic [15:0] we_log_b[$];
   int          re_cnt_a = 0;

   always @(negedge clk) begin
      if (if_a.reg_we) we_log_a.push_back({2'b00, if_a.reg_addr, if_a.reg_wdata});
      if (if_b.reg_we) we_log_b.push_back({2'b00, if_b.reg_addr, if_b.reg_wdata});
      if (if_a.reg_re) re_cnt_a++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      data_in   = b;
      byte_sync = 1'b1;
      @(negedge clk);
      byte_sync = 1'b0;
      tick(8);
   endtask

   task automatic frame_start();
      @(negedge clk);
      cs_n = 1'b0;
      tick(4);
   endtask

   task automatic frame_end();
      @(negedge clk);
      cs_n = 1'b1;
      tick(4);
   endtask

   task automatic pulse_err_clr();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      tick(1);
   endtask

   task automatic test_reset();
      tick(3);
      checks++; if (if_a.data_out !== 8'hA5) begin errors++; $display("FAIL reset_data_out: got %h expected a5", if_a.data_out); end
      checks++; if (if_a.reg_addr !== 6'h00) begin errors++; $display("FAIL reset_reg_addr: got %h expected 00", if_a.reg_addr); end
      checks++; if (if_a.reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_reg_wdata: got %h expected 00", if_a.reg_wdata); end
      checks++; if (if_a.reg_we !== 1'b0) begin errors++; $display("FAIL reset_reg_we: got %b expected 0", if_a.reg_we); end
      checks++; if (if_a.reg_re !== 1'b0) begin errors++; $display("FAIL reset_reg_re: got %b expected 0", if_a.reg_re); end
      checks++; if (if_a.err_flag !== 1'b0) begin errors++; $display("FAIL reset_err_flag: got %b expected 0", if_a.err_flag); end
      checks++; if (if_b.data_out !== 8'hA5) begin errors++; $display("FAIL reset_data_out_b: got %h expected a5", if_b.data_out); end
      @(negedge clk);
      rst_n = 1'b1;
      tick(4);
   endtask

   task automatic test_write();
      int base;
      base = we_log_a.size();
      frame_start();
      send_byte(8'h85);
      send_byte(8'h3C);
      frame_end();
      checks++; if (we_log_a.size() - base !== 1) begin errors++; $display("FAIL write_count: got %0d expected 1", we_log_a.size() - base); end
      if (we_log_a.size() > base) begin
         checks++; if (we_log_a[base] !== 16'h053C) begin errors++; $display("FAIL write_entry: got %h expected 053c", we_log_a[base]); end
      end
      checks++; if (if_a.err_flag !== 1'b0) begin errors++; $display("FAIL write_err: got %b expected 0", if_a.err_flag); end
   endtask

   task automatic test_read();
      int base;
      reg_rdata = 8'h3C;
      frame_start();
      checks++; if (if_a.data_out !== 8'hA5) begin errors++; $display("FAIL read_byte0: got %h expected a5", if_a.data_out); end
      base = re_cnt_a;
      send_byte(8'h05);
      checks++; if (if_a.data_out !== 8'h3C) begin errors++; $display("FAIL read_byte1: got %h expected 3c", if_a.data_out); end
      checks++; if (re_cnt_a - base !== 1) begin errors++; $display("FAIL read_re_cmd: got %0d expected 1", re_cnt_a - base); end
      send_byte(8'h00);
      checks++; if (re_cnt_a - base !== 2) begin errors++; $display("FAIL read_re_data: got %0d expected 2", re_cnt_a - base); end
      frame_end();
      checks++; if (if_a.data_out !== 8'hA5) begin errors++; $display("FAIL read_idle_data_out: got %h expected a5", if_a.data_out); end
   endtask

   task automatic test_burst_write();
      int base;
      base = we_log_a.size();
      frame_start();
      send_byte(8'hFE);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      frame_end();
      checks++; if (we_log_a.size() - base !== 3) begin errors++; $display("FAIL burst_count: got %0d expected 3", we_log_a.size() - base); end
      if (we_log_a.size() - base >= 3) begin
         checks++; if (we_log_a[base] !== 16'h3E11) begin errors++; $display("FAIL burst_w0: got %h expected 3e11", we_log_a[base]); end
         checks++; if (we_log_a[base+1] !== 16'h3F22) begin errors++; $display("FAIL burst_w1: got %h expected 3f22", we_log_a[base+1]); end
         checks++; if (we_log_a[base+2] !== 16'h0033) begin errors++; $display("FAIL burst_wrap: got %h expected 0033", we_log_a[base+2]); end
      end
   endtask

   task automatic test_out_of_range();
      int base;
      // dut_b saw the burst to 3E/3F, which is beyond its 32 registers.
      checks++; if (if_b.err_flag !== 1'b1) begin errors++; $display("FAIL oor_burst_err: got %b expected 1", if_b.err_flag); end
      pulse_err_clr();
      checks++; if (if_b.err_flag !== 1'b0) begin errors++; $display("FAIL oor_clr1: got %b expected 0", if_b.err_flag); end
      base = we_log_b.size();
      frame_start();
      send_byte(8'hA8);
      send_byte(8'h77);
      frame_end();
      checks++; if (we_log_b.size() - base !== 0) begin errors++; $display("FAIL oor_no_we: got %0d expected 0", we_log_b.size() - base); end
      checks++; if (if_b.err_flag !== 1'b1) begin errors++; $display("FAIL oor_write_err: got %b expected 1", if_b.err_flag); end
      reg_rdata = 8'h3C;
      frame_start();
      send_byte(8'h28);
      checks++; if (if_b.data_out !== 8'h00) begin errors++; $display("FAIL oor_read_zero: got %h expected 00", if_b.data_out); end
      checks++; if (if_a.data_out !== 8'h3C) begin errors++; $display("FAIL inrange_read_28: got %h expected 3c", if_a.data_out); end
      frame_end();
      pulse_err_clr();
      checks++; if (if_b.err_flag !== 1'b0) begin errors++; $display("FAIL oor_clr2: got %b expected 0", if_b.err_flag); end
      // Set and clear in the same cycle: set wins.
      frame_start();
      send_byte(8'hA8);
      @(negedge clk);
      data_in   = 8'h99;
      byte_sync = 1'b1;
      err_clr   = 1'b1;
      @(negedge clk);
      byte_sync = 1'b0;
      err_clr   = 1'b0;
      tick(2);
      checks++; if (if_b.err_flag !== 1'b1) begin errors++; $display("FAIL oor_set_wins: got %b expected 1", if_b.err_flag); end
      frame_end();
      pulse_err_clr();
      checks++; if (if_a.err_flag !== 1'b0) begin errors++; $display("FAIL inrange_err_a: got %b expected 0", if_a.err_flag); end
   endtask

   task automatic test_abort();
      int base;
      base = we_log_a.size();
      frame_start();
      send_byte(8'h81);
      tick(4);
      frame_end();
      checks++; if (we_log_a.size() - base !== 0) begin errors++; $display("FAIL abort_no_we: got %0d expected 0", we_log_a.size() - base); end
      frame_start();
      send_byte(8'h81);
      send_byte(8'h55);
      frame_end();
      checks++; if (we_log_a.size() - base !== 1) begin errors++; $display("FAIL abort_next_count: got %0d expected 1", we_log_a.size() - base); end
      if (we_log_a.size() > base) begin
         checks++; if (we_log_a[base] !== 16'h0155) begin errors++; $display("FAIL abort_next_entry: got %h expected 0155", we_log_a[base]); end
      end
   endtask

   task automatic test_reset_midframe();
      int base;
      reg_rdata = 8'h5A;
      frame_start();
      send_byte(8'h45);
      send_byte(8'h00);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (if_a.data_out !== 8'hA5) begin errors++; $display("FAIL rst_mid_data_out: got %h expected a5", if_a.data_out); end
      checks++; if (if_a.reg_addr !== 6'h00) begin errors++; $display("FAIL rst_mid_reg_addr: got %h expected 00", if_a.reg_addr); end
      checks++; if (if_a.reg_wdata !== 8'h00) begin errors++; $display("FAIL rst_mid_reg_wdata: got %h expected 00", if_a.reg_wdata); end
      checks++; if (if_a.reg_re !== 1'b0) begin errors++; $display("FAIL rst_mid_reg_re: got %b expected 0", if_a.reg_re); end
      checks++; if (if_a.reg_we !== 1'b0) begin errors++; $display("FAIL rst_mid_reg_we: got %b expected 0", if_a.reg_we); end
      @(negedge clk);
      rst_n = 1'b1;
      tick(2);
      // Remainder of the interrupted frame must not be decoded.
      base = we_log_a.size();
      send_byte(8'h81);
      send_byte(8'h99);
      frame_end();
      checks++; if (we_log_a.size() - base !== 0) begin errors++; $display("FAIL rst_mid_ignored: got %0d expected 0", we_log_a.size() - base); end
      frame_start();
      send_byte(8'h82);
      send_byte(8'h66);
      frame_end();
      checks++; if (we_log_a.size() - base !== 1) begin errors++; $display("FAIL rst_next_count: got %0d expected 1", we_log_a.size() - base); end
      if (we_log_a.size() > base) begin
         checks++; if (we_log_a[base] !== 16'h0266) begin errors++; $display("FAIL rst_next_entry: got %h expected 0266", we_log_a[base]); end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_burst_write();
      test_out_of_range();
      test_abort();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
